// File: rtl/freq_div_pkg.sv
// Shared constants and handshake state type for the programmable clock divider.
package freq_div_pkg;

    localparam int unsigned RATIO_W     = 10;
    localparam int unsigned MIN_RATIO   = 2;
    localparam int unsigned RESET_RATIO = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } upd_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/freq_div_by_n.sv
// Programmable integer clock divider with glitch-free bypass and a req/ack
// ratio update that only takes effect on a divided-period boundary.
module freq_div_by_n #(
    parameter int unsigned RATIO_W     = freq_div_pkg::RATIO_W,
    parameter int unsigned RESET_RATIO = freq_div_pkg::RESET_RATIO
) (
    input  logic               clkin,
    input  logic               rstb,
    input  logic               bypass,
    input  logic [RATIO_W-1:0] ratio,
    input  logic               ratio_upd_req,
    output logic               ratio_upd_ack,
    output logic               clkout
);

    import freq_div_pkg::MIN_RATIO;
    import freq_div_pkg::upd_state_e;
    import freq_div_pkg::IDLE;
    import freq_div_pkg::WAIT;
    import freq_div_pkg::ACK;

    logic [RATIO_W-1:0] n_act;
    logic [RATIO_W-1:0] cnt;
    logic [RATIO_W-1:0] hi_c;
    logic [RATIO_W-1:0] n_load_c;
    logic               div_clk;
    logic               sel;
    logic               req_s;
    logic               byp_s;
    logic               wrap_c;
    logic               load_c;
    logic               ack_next_c;
    upd_state_e         state;
    upd_state_e         state_next;

    sync_2ff u_sync_req (
        .clk   (clkin),
        .rst_n (rstb),
        .d     (ratio_upd_req),
        .q     (req_s)
    );

    sync_2ff u_sync_byp (
        .clk   (clkin),
        .rst_n (rstb),
        .d     (bypass),
        .q     (byp_s)
    );

    assign wrap_c   = (cnt == n_act - RATIO_W'(1));
    assign hi_c     = n_act - (n_act >> 1);
    assign n_load_c = (ratio < RATIO_W'(MIN_RATIO)) ? RATIO_W'(MIN_RATIO) : ratio;

    // Free-running divider; a load only ever coincides with the natural wrap.
    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            cnt     <= '0;
            div_clk <= 1'b0;
            n_act   <= RATIO_W'(RESET_RATIO);
        end else begin
            div_clk <= (cnt < hi_c);
            cnt     <= wrap_c ? '0 : cnt + RATIO_W'(1);
            if (load_c) begin
                n_act <= n_load_c;
            end
        end
    end

    always_ff @(posedge clkin or negedge rstb) begin
        if (!rstb) begin
            state         <= IDLE;
            ratio_upd_ack <= 1'b0;
        end else begin
            state         <= state_next;
            ratio_upd_ack <= ack_next_c;
        end
    end

    always_comb begin
        state_next = state;
        ack_next_c = ratio_upd_ack;
        load_c     = 1'b0;
        case (state)
            IDLE: begin
                if (req_s) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wrap_c) begin
                    load_c     = 1'b1;
                    ack_next_c = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    ack_next_c = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                ack_next_c = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Select moves only while clkin is low and div_clk is low, so both mux inputs are low.
    always_ff @(negedge clkin or negedge rstb) begin
        if (!rstb) begin
            sel <= 1'b0;
        end else if (!div_clk) begin
            sel <= byp_s;
        end
    end

    assign clkout = sel ? clkin : div_clk;

    ack_at_boundary: assert property (
        @(posedge clkin) disable iff (!rstb) $rose(ratio_upd_ack) |-> (cnt == '0)
    );

    sel_switch_when_low: assert property (
        @(negedge clkin) disable iff (!rstb) (sel != $past(sel)) |-> !$past(div_clk)
    );

    ratio_stable_during_req: assert property (
        @(posedge clkin) disable iff (!rstb)
            (ratio_upd_req && $past(ratio_upd_req)) |-> $stable(ratio)
    );

endmodule

// File: tb/tb_freq_div_by_n.sv
// Self-checking bench: directed steps plus random ratios/phases against an arithmetic period model.
module tb_freq_div_by_n;

    logic       clkin = 1'b0;
    logic       rstb = 1'b0;
    logic       bypass = 1'b0;
    logic [9:0] ratio = 10'd0;
    logic       ratio_upd_req = 1'b0;
    logic       ratio_upd_ack;
    logic       clkout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rise = 0;
    int cur_n = 2;
    logic cur = 1'b0;
    logic prev = 1'b0;

    bit      mon_en = 1'b0;
    realtime last_edge = 0.0;
    realtime min_w = 1.0e6;

    always #5 clkin = ~clkin;

    freq_div_by_n dut (
        .clkin         (clkin),
        .rstb          (rstb),
        .bypass        (bypass),
        .ratio         (ratio),
        .ratio_upd_req (ratio_upd_req),
        .ratio_upd_ack (ratio_upd_ack),
        .clkout        (clkout)
    );

    // Narrowest clkout pulse seen while monitoring is enabled.
    always @(clkout) begin
        if (mon_en && (($realtime - last_edge) < min_w)) min_w = $realtime - last_edge;
        last_edge = $realtime;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int got, input int lo, input int hi);
        checks++;
        assert (got >= lo && got <= hi) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=[%0d..%0d]", tag, got, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
        cyc++;
        prev = cur;
        cur  = clkout;
        if (cur === 1'b1 && prev === 1'b0) last_rise = cyc;
    endtask

    task automatic wait_edge(input logic lvl, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (cur === lvl && prev !== lvl) begin
                t = cyc;
                break;
            end
        end
        chk("edge_timeout", (t >= 0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Expected period = max(r,2), high time = ceil(period/2).
    task automatic check_periods(input int r, input int k);
        int n, hi, t0, t1, t2;
        n  = (r < 2) ? 2 : r;
        hi = (n + 1) / 2;
        wait_edge(1'b1, 2 * n + 4, t0);
        for (int i = 0; i < k; i++) begin
            wait_edge(1'b0, n + 2, t1);
            wait_edge(1'b1, n + 2, t2);
            chk("high_time", t1 - t0, hi);
            chk("period", t2 - t0, n);
            t0 = t2;
        end
    endtask

    task automatic do_update(input int r);
        int n_old, n_new, t_req, t_ack, t_fall, t1, t2, t3;
        n_old = cur_n;
        n_new = (r < 2) ? 2 : r;
        t_ack = -1;
        t_fall = -1;
        ratio = 10'(r);
        step();
        t_req = cyc;
        ratio_upd_req = 1'b1;
        for (int i = 0; i < n_old + 8; i++) begin
            step();
            if (ratio_upd_ack === 1'b1) begin
                t_ack = cyc;
                break;
            end
        end
        chk("ack_seen", (t_ack >= 0) ? 32'd1 : 32'd0, 32'd1);
        chk_range("ack_latency", t_ack - t_req, 2, 3 + n_old);
        chk("old_period_full", t_ack + 1 - last_rise, n_old);
        wait_edge(1'b1, 4, t1);
        chk("new_period_start", t1, t_ack + 1);
        wait_edge(1'b0, n_new + 2, t2);
        wait_edge(1'b1, n_new + 2, t3);
        chk("first_new_high", t2 - t1, (n_new + 1) / 2);
        chk("first_new_period", t3 - t1, n_new);
        step();
        t_req = cyc;
        ratio_upd_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ratio_upd_ack === 1'b0) begin
                t_fall = cyc;
                break;
            end
        end
        chk("ack_fall_latency", t_fall - t_req, 3);
        cur_n = n_new;
        check_periods(r, 1);
    endtask

    initial begin
        int r;

        // Reset default: output and ack held low throughout reset
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_clkout", 32'(clkout), 32'd0);
            chk("rst_ack", 32'(ratio_upd_ack), 32'd0);
        end
        rstb = 1'b1;
        step();
        chk("first_edge", 32'(cur), 32'd1);
        repeat (2) step();
        mon_en = 1'b1;
        check_periods(2, 3);
        chk("idle_ack", 32'(ratio_upd_ack), 32'd0);

        // Odd ratio, then the sweep
        do_update(7);
        check_periods(7, 2);
        do_update(10);
        do_update(25);
        do_update(40);
        do_update(1023);

        // Random ratios at random phases
        for (int i = 0; i < 3; i++) begin
            r = int'($urandom_range(3, 60));
            repeat ($urandom_range(0, 20)) step();
            do_update(r);
        end

        // Clamp
        do_update(0);
        check_periods(0, 2);
        do_update(1);
        check_periods(1, 2);

        // Bypass at random phase
        do_update(15);
        repeat ($urandom_range(0, 15)) step();
        #($urandom_range(1, 8));
        bypass = 1'b1;
        repeat (12) step();
        for (int i = 0; i < 100; i++) begin
            step();
            chk("bypass_high", 32'(clkout), 32'd1);
            @(negedge clkin);
            #1;
            chk("bypass_low", 32'(clkout), 32'd0);
        end
        #($urandom_range(0, 3));
        bypass = 1'b0;
        repeat (14) step();
        check_periods(15, 2);
        chk_range("min_pulse_x100", int'(min_w * 100.0), 500, 100000000);

        // Reset during WAIT
        ratio = 10'd100;
        step();
        ratio_upd_req = 1'b1;
        repeat (3) step();
        mon_en = 1'b0;
        #2;
        rstb = 1'b0;
        #1;
        chk("midrst_ack", 32'(ratio_upd_ack), 32'd0);
        chk("midrst_clkout", 32'(clkout), 32'd0);
        ratio_upd_req = 1'b0;
        repeat (3) step();
        chk("midrst_hold", 32'(clkout), 32'd0);
        rstb = 1'b1;
        step();
        chk("midrst_first_edge", 32'(cur), 32'd1);
        cur_n = 2;
        check_periods(2, 2);
        chk("midrst_idle_ack", 32'(ratio_upd_ack), 32'd0);
        mon_en = 1'b1;
        do_update(9);
        check_periods(9, 1);
        chk_range("min_pulse_final_x100", int'(min_w * 100.0), 500, 100000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
